// File: rtl/barrel_pkg.sv
// barrel_pkg: shared encodings, widths and LFSR constants for the barrel subsystem
package barrel_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  typedef enum logic [1:0] {B_IDLE = 2'd0, B_ROLL = 2'd1, B_FALL = 2'd2, B_DONE = 2'd3} barrel_state_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} sched_state_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11)
module lfsr16
  import barrel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) lfsr_q <= rst ? LFSR_SEED : lfsr_next(lfsr_q);
  assign value_o = lfsr_q;
endmodule

// File: rtl/barrel_scheduler.sv
// barrel_scheduler: spawns, retires and collision-checks a pool of barrel instances
module barrel_scheduler
  import barrel_pkg::*;
#(
  parameter int          N_SLOTS     = 4,
  parameter int          SPAWN_BASE  = 50000000,
  parameter logic [15:0] JITTER_MASK = 16'h3FFF,
  parameter int          HIT_W       = 16,
  parameter int          HIT_H       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   game_start,
  input  logic                   game_over,
  input  logic [X_W-1:0]         mario_x,
  input  logic [Y_W-1:0]         mario_y,
  input  logic [X_W*N_SLOTS-1:0] barrel_x,
  input  logic [Y_W*N_SLOTS-1:0] barrel_y,
  input  logic [2*N_SLOTS-1:0]   barrel_state,
  output logic [N_SLOTS-1:0]     slot_run,
  output logic [N_SLOTS-1:0]     slot_rst,
  output logic                   slot_over,
  output logic                   hit,
  output logic [7:0]             spawn_count,
  output logic [1:0]             sched_state
);
  localparam int IW = $clog2(N_SLOTS);
  localparam int TW = 32;
  sched_state_e        state_q, state_d;
  logic [N_SLOTS-1:0]  run_q, run_d, rst_q, rst_d;
  logic                over_q, over_d, hit_q, hit_d, s1_q, s1_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [15:0]         lfsr;
  logic [N_SLOTS-1:0]  free, done, pick;
  logic [X_W-1:0]      bx [N_SLOTS];
  logic [Y_W-1:0]      by [N_SLOTS];
  logic [1:0]          bs [N_SLOTS];
  logic [X_W:0]        dx, adx;
  logic [Y_W:0]        dy, ady;
  logic                active;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .value_o(lfsr));

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    assign bx[g]   = barrel_x[g*X_W +: X_W];
    assign by[g]   = barrel_y[g*Y_W +: Y_W];
    assign bs[g]   = barrel_state[2*g +: 2];
    assign free[g] = !run_q[g] && !rst_q[g] && bs[g] == B_IDLE;
    assign done[g] = run_q[g] && bs[g] == B_DONE;
  end

  // isolate the lowest set bit of the free mask
  assign pick = free & (~free + N_SLOTS'(1));

  // zero-extended differences keep the sign bit, so no wrap-around at screen edges
  assign dx     = {1'b0, bx[idx_q]} - {1'b0, mario_x};
  assign dy     = {1'b0, by[idx_q]} - {1'b0, mario_y};
  assign adx    = dx[X_W] ? -dx : dx;
  assign ady    = dy[Y_W] ? -dy : dy;
  assign active = run_q[idx_q] && (bs[idx_q] == B_ROLL || bs[idx_q] == B_FALL);
  assign s1_d   = state_q == S_RUN && active && adx < (X_W+1)'(HIT_W) && ady < (Y_W+1)'(HIT_H);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rst_d   = '0;
    over_d  = over_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        run_d  = '0;
        over_d = 1'b0;
        if (game_start) begin
          state_d = S_RUN;
          timer_d = TW'(SPAWN_BASE);
        end
      end
      S_RUN: begin
        idx_d = idx_q == IW'(N_SLOTS - 1) ? '0 : idx_q + IW'(1);
        hit_d = hit_q | s1_q;
        if (game_over || hit_d) begin
          state_d = S_OVER;
          run_d   = '0;
          over_d  = 1'b1;
        end else begin
          rst_d = done;
          run_d = run_q & ~done;
          if (timer_q != '0) timer_d = timer_q - TW'(1);
          else if (|free) begin
            run_d   = run_d | pick;
            cnt_d   = cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
            timer_d = TW'(SPAWN_BASE) + TW'(lfsr & JITTER_MASK);
          end
        end
      end
      S_OVER: begin
        run_d  = '0;
        over_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      rst_q   <= '0;
      over_q  <= 1'b0;
      hit_q   <= 1'b0;
      s1_q    <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      rst_q   <= rst_d;
      over_q  <= over_d;
      hit_q   <= hit_d;
      s1_q    <= s1_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

  assign slot_run    = run_q;
  assign slot_rst    = rst_q;
  assign slot_over   = over_q;
  assign hit         = hit_q;
  assign spawn_count = cnt_q;
  assign sched_state = state_q;
endmodule

// File: tb/tb_barrel_scheduler.sv
// tb_barrel_scheduler: directed checks of spawn timing, pool limits, retire, collision and over
module tb_barrel_scheduler;
  logic        clk = 1'b0;
  logic        rst, game_start, game_over;
  logic [9:0]  mario_x;
  logic [8:0]  mario_y;
  logic [9:0]  bx [4];
  logic [8:0]  by [4];
  logic [1:0]  bs [4];
  logic [3:0]  slot_run, slot_rst;
  logic        slot_over, hit;
  logic [7:0]  spawn_count;
  logic [1:0]  sched_state;
  int          n_chk = 0;
  int          n_fail = 0;

  barrel_scheduler #(.N_SLOTS(4), .SPAWN_BASE(10), .JITTER_MASK(16'h0000), .HIT_W(16), .HIT_H(16)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .mario_x(mario_x), .mario_y(mario_y),
    .barrel_x({bx[3], bx[2], bx[1], bx[0]}),
    .barrel_y({by[3], by[2], by[1], by[0]}),
    .barrel_state({bs[3], bs[2], bs[1], bs[0]}),
    .slot_run(slot_run), .slot_rst(slot_rst), .slot_over(slot_over), .hit(hit),
    .spawn_count(spawn_count), .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(sched_state), 0);
    chk({tag, "_run"}, 32'(slot_run), 0);
    chk({tag, "_rst"}, 32'(slot_rst), 0);
    chk({tag, "_over"}, 32'(slot_over), 0);
    chk({tag, "_hit"}, 32'(hit), 0);
    chk({tag, "_cnt"}, 32'(spawn_count), 0);
  endtask

  task automatic wait_hit(input string tag);
    for (int i = 0; i < 5 && hit !== 1'b1; i++) tick(1);
    chk(tag, 32'(hit), 1);
  endtask

  task automatic park();
    for (int k = 0; k < 4; k++) begin
      bx[k] = '0;
      by[k] = '0;
      bs[k] = 2'd0;
    end
    mario_x = 10'd900;
    mario_y = 9'd450;
  endtask

  initial begin
    rst = 1'b1; game_start = 1'b0; game_over = 1'b0;
    park();
    tick(2);
    chk_reset("reset");
    // round 1: spawn timing and full pool
    rst = 1'b0; game_start = 1'b1;
    tick(1);
    game_start = 1'b0;
    chk("enter_run", 32'(sched_state), 1);
    tick(10);
    chk("no_spawn_yet", 32'(slot_run), 4'b0000);
    tick(1);
    chk("spawn1_run", 32'(slot_run), 4'b0001);
    chk("spawn1_cnt", 32'(spawn_count), 1);
    tick(10);
    chk("gap_run", 32'(slot_run), 4'b0001);
    tick(1);
    chk("spawn2_run", 32'(slot_run), 4'b0011);
    chk("spawn2_cnt", 32'(spawn_count), 2);
    bs[0] = 2'd1; bs[1] = 2'd1;
    tick(11);
    chk("spawn3_run", 32'(slot_run), 4'b0111);
    bs[2] = 2'd1;
    tick(11);
    chk("spawn4_run", 32'(slot_run), 4'b1111);
    chk("spawn4_cnt", 32'(spawn_count), 4);
    bs[3] = 2'd1;
    tick(15);
    chk("full_hold_run", 32'(slot_run), 4'b1111);
    chk("full_hold_cnt", 32'(spawn_count), 4);
    bs[2] = 2'd3;
    tick(1);
    chk("retire_run", 32'(slot_run), 4'b1011);
    chk("retire_pulse", 32'(slot_rst), 4'b0100);
    bs[2] = 2'd0;
    tick(1);
    chk("pulse_end", 32'(slot_rst), 4'b0000);
    chk("rst_blocks_reuse", 32'(slot_run), 4'b1011);
    tick(1);
    chk("reuse_run", 32'(slot_run), 4'b1111);
    chk("reuse_cnt", 32'(spawn_count), 5);
    bs[2] = 2'd1;
    // collision on slot 1
    bx[1] = 10'd100; by[1] = 9'd200;
    mario_x = 10'd110; mario_y = 9'd190;
    wait_hit("hit_slot1");
    chk("hit_state", 32'(sched_state), 2);
    chk("hit_over", 32'(slot_over), 1);
    chk("hit_run", 32'(slot_run), 4'b0000);
    tick(3);
    chk("over_hold_state", 32'(sched_state), 2);
    chk("over_hold_hit", 32'(hit), 1);
    chk("over_hold_cnt", 32'(spawn_count), 5);
    chk("over_no_pulse", 32'(slot_rst), 4'b0000);
    // round 2: boundary miss, inactive overlaps, external over
    rst = 1'b1;
    tick(1);
    chk_reset("reset2");
    park();
    bx[1] = 10'd100; by[1] = 9'd200;
    bx[2] = 10'd100; by[2] = 9'd200;
    mario_x = 10'd116; mario_y = 9'd200;
    rst = 1'b0; game_start = 1'b1;
    tick(1);
    game_start = 1'b0;
    tick(11);
    chk("r2_spawn1", 32'(slot_run), 4'b0001);
    bs[0] = 2'd1;
    tick(11);
    chk("r2_spawn2", 32'(slot_run), 4'b0011);
    bs[1] = 2'd1;
    tick(6);
    chk("edge_miss_hit", 32'(hit), 0);
    chk("edge_miss_state", 32'(sched_state), 1);
    bs[1] = 2'd3; bs[2] = 2'd1;
    mario_x = 10'd100;
    tick(1);
    chk("r2_retire_run", 32'(slot_run), 4'b0001);
    chk("r2_retire_pulse", 32'(slot_rst), 4'b0010);
    tick(4);
    chk("r2_spawn3_run", 32'(slot_run), 4'b1001);
    chk("r2_spawn3_cnt", 32'(spawn_count), 3);
    chk("inactive_hit", 32'(hit), 0);
    bs[1] = 2'd0;
    tick(10);
    chk("pre_over_state", 32'(sched_state), 1);
    chk("inactive_hit2", 32'(hit), 0);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    chk("ext_over_state", 32'(sched_state), 2);
    chk("ext_over_cnt", 32'(spawn_count), 3);
    chk("ext_over_run", 32'(slot_run), 4'b0000);
    chk("ext_over_over", 32'(slot_over), 1);
    chk("ext_over_hit", 32'(hit), 0);
    // round 3: reset mid-round, then resume and boundary hit
    rst = 1'b1;
    tick(1);
    park();
    rst = 1'b0; game_start = 1'b1;
    tick(1);
    game_start = 1'b0;
    tick(11);
    chk("r3_spawn1", 32'(slot_run), 4'b0001);
    bs[0] = 2'd1;
    tick(11);
    chk("r3_spawn2", 32'(slot_run), 4'b0011);
    bs[0] = 2'd3;
    tick(1);
    chk("r3_retire_pulse", 32'(slot_rst), 4'b0001);
    tick(10);
    chk("r3_pool", 32'(slot_run), 4'b0110);
    chk("r3_cnt", 32'(spawn_count), 3);
    rst = 1'b1;
    tick(1);
    chk_reset("midreset");
    park();
    rst = 1'b0; game_start = 1'b1;
    tick(1);
    game_start = 1'b0;
    chk("resume_state", 32'(sched_state), 1);
    tick(11);
    chk("resume_run", 32'(slot_run), 4'b0001);
    chk("resume_cnt", 32'(spawn_count), 1);
    bs[0] = 2'd2; bx[0] = 10'd100; by[0] = 9'd200;
    mario_x = 10'd115; mario_y = 9'd185;
    wait_hit("edge_hit");
    chk("edge_hit_state", 32'(sched_state), 2);
    chk("edge_hit_run", 32'(slot_run), 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/barrel_scheduler.md
Name: barrel_scheduler

Overview:
Owns a pool of N_SLOTS barrel instances and drives each barrel's start/over/reset controls.
- Spawns barrels on a jittered timer into the lowest free slot.
- Retires barrels that report DONE and recycles their slots.
- Round-robin scans barrel positions against Mario's position and raises a hit. A hit or an external game_over forces game-over to every barrel.
- Sits between the game top-level FSM and the barrel instances.

Parameters:
N_SLOTS, 4, number of barrel instances managed (2..8)
SPAWN_BASE, 50000000, minimum clk cycles between spawns (1 s at 50 MHz)
JITTER_MASK, 16'h3FFF, AND-mask on LFSR value added to SPAWN_BASE at each reload
HIT_W, 16, horizontal overlap threshold in pixels
HIT_H, 16, vertical overlap threshold in pixels

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
game_start  in  1  level; begins a round from IDLE
game_over  in  1  level; external end-of-round request
mario_x  in  10  Mario x pixel
mario_y  in  9  Mario y pixel
barrel_x  in  10*N_SLOTS  packed barrel x; slot k at [10k+9:10k]
barrel_y  in  9*N_SLOTS  packed barrel y
barrel_state  in  2*N_SLOTS  packed barrel state (IDLE/ROLL/FALL/DONE)
slot_run  out  N_SLOTS  level start to each barrel
slot_rst  out  N_SLOTS  one-cycle retire pulse to each barrel
slot_over  out  1  broadcast over to all barrels
hit  out  1  sticky; collision detected this round
spawn_count  out  8  barrels spawned this round, saturates at 255
sched_state  out  2  controller state

Behaviour:
- Single clock domain. rst is synchronous, active-high, and overrides everything.
- Reset values:
  - sched_state=S_IDLE.
  - slot_run=0, slot_rst=0, slot_over=0, hit=0, spawn_count=0.
  - timer=0, scan_idx=0.
  - LFSR=16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including under reset-release and in all states.
- S_IDLE:
  - game_start=1 -> S_RUN next cycle.
  - On that transition, timer loads SPAWN_BASE.
- S_RUN, spawn:
  - timer decrements by 1 per cycle while nonzero.
  - Slot k is free when slot_run[k]=0, slot_rst[k]=0 and barrel_state[k]=IDLE.
  - timer==0 and a free slot exists: set slot_run[lowest free k]=1, increment spawn_count (saturating), reload timer with SPAWN_BASE+(lfsr&JITTER_MASK).
  - timer==0 and no free slot: timer holds 0 and the spawn fires in the first cycle a slot becomes free.
  - At most one spawn per cycle.
- S_RUN, retire:
  - slot_run[k]=1 and barrel_state[k]=DONE: next cycle slot_run[k]=0 and slot_rst[k]=1 for exactly one cycle.
  - The slot is reusable once the barrel reports IDLE.
  - Multiple slots may retire in the same cycle.
- S_RUN, collision (2-stage pipeline):
  - scan_idx increments mod N_SLOTS every cycle.
  - Stage 1 registers: |barrel_x[scan_idx]-mario_x| < HIT_W, |barrel_y[scan_idx]-mario_y| < HIT_H, and slot_run[scan_idx]=1 and state is ROLL or FALL.
  - Differences are computed 11-bit/10-bit signed; there is no wrap-around.
  - Stage 2 sets hit.
  - Worst-case latency from a steady overlap to hit=1 is N_SLOTS+1 cycles.
- S_RUN -> S_OVER when hit is set or game_over=1.
  - Same-cycle spawn and over: over wins, no spawn, spawn_count unchanged.
- S_OVER:
  - slot_over=1, slot_run=0, no spawns, no retire pulses.
  - hit holds.
  - Exits only on rst.
- Reset mid-round: all outputs return to reset values on the next edge; barrels are reset by the system rst.
- sched_state encoding: S_IDLE=0, S_RUN=1, S_OVER=2. Value 3 is unused and recovers to S_IDLE.

Decomposition:
- Package barrel_pkg:
  - barrel state encodings: IDLE=0, ROLL=1, FALL=2, DONE=3.
  - scheduler state encodings.
  - LFSR seed 16'hACE1 and tap constants.
  - coordinate widths: X_W=10, Y_W=9.
- Sub-module lfsr16: clk, rst, 16-bit output, free-running. It is reused by other game randomness.
- Free-slot priority encoder and hit comparator stay inline.

Test Plan:
All tests use N_SLOTS=4, SPAWN_BASE=10, JITTER_MASK=0.
- Spawn timing: rst, then game_start=1 with barrels held IDLE -> slot_run 0001 eleven cycles after S_RUN entry, then 0011 eleven cycles later; spawn_count 1 then 2.
- Pool full: hold all barrel_state=ROLL -> four spawns fill slot_run=1111; timer holds 0. Set slot 2 DONE -> next cycle slot_run=1011, slot_rst=0100 for 1 cycle. Return slot 2 to IDLE -> slot_run=1111 the following cycle; spawn_count=5.
- Collision: slot 1 ROLL at (100,200), Mario at (110,190) -> hit=1 within 5 cycles, S_OVER, slot_over=1, slot_run=0000. Mario at (116,200) -> no hit.
- Inactive overlap ignored: barrel_state=DONE or slot_run=0 at Mario's exact position -> hit stays 0.
- External over: game_over=1 coincident with timer==0 -> no spawn, spawn_count unchanged, S_OVER next cycle.
- Reset mid-round: rst=1 during S_RUN with slot_run=0110 -> next edge all outputs at reset values. Then rst=0, game_start=1 -> S_RUN and spawns resume from slot 0.
